// File: rtl/otter_bp_pkg.sv
// otter_bp_pkg
// Shared helpers for the OTTER branch predictor: PC-to-index and PC-to-tag
// field extraction, and the weakly-taken initial value for a freshly
// allocated direction counter. Widths are passed as arguments so a single
// function body serves every parameterisation; callers truncate the
// 32-bit result to their own field width.
package otter_bp_pkg;

  // Word-aligned index: pc[idx_w+1:2].
  function automatic logic [31:0] bp_index(input logic [63:0] pc, input int idx_w);
    logic [63:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return 32'((pc >> 2) & mask);
  endfunction

  // Tag sits directly above the index: pc[idx_w+tag_w+1:idx_w+2].
  function automatic logic [31:0] bp_tag(input logic [63:0] pc, input int idx_w,
                                         input int tag_w);
    logic [63:0] mask;
    mask = (64'd1 << tag_w) - 64'd1;
    return 32'((pc >> (idx_w + 2)) & mask);
  endfunction

  // Weakly taken: only the MSB of the counter set, i.e. 2^(ctr_w-1).
  function automatic logic [31:0] weak_taken_init(input int ctr_w);
    return 32'd1 << (ctr_w - 1);
  endfunction

endpackage

// File: rtl/otter_sat_ctr.sv
// otter_sat_ctr
// W-bit saturating up/down counter with parallel load. Used once per
// predictor entry as the direction counter and again, 32 bits wide, for
// the performance counters.
// Ports:
//   CLK, RESET       clock, asynchronous active-high reset (count -> 0)
//   inc, dec         step up / down; both together hold the value
//   load, load_val   parallel load, takes priority over inc/dec
//   count            current value
module otter_sat_ctr #(
  parameter int W = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (inc && !dec && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end else if (dec && !inc && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/otter_branch_predictor.sv
// otter_branch_predictor
// Direct-mapped branch history table of saturating direction counters
// combined with a tagged branch target buffer, held in flops so the fetch
// stage can read it combinationally. EX-stage resolutions train the table
// on the following edge; there is no bypass from update to lookup.
// Ports:
//   CLK, RESET                   clock, asynchronous active-high reset
//   lookup_pc                    fetch PC
//   pred_taken, pred_target      predicted redirect and next PC
//   upd_valid, upd_pc,
//   upd_taken, upd_target,
//   upd_mispredict               resolved control-flow report from EX
//   bp_clear                     synchronous invalidate of all entries
//   branch_cnt, mispredict_cnt   saturating performance counters
module otter_branch_predictor
  import otter_bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_mispredict,
  input  logic            bp_clear,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0] ctr_q    [ENTRIES];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit, wr_en;

  assign l_idx = IDX_W'(bp_index(64'(lookup_pc), IDX_W));
  assign l_tag = TAG_W'(bp_tag(64'(lookup_pc), IDX_W, TAG_W));
  assign u_idx = IDX_W'(bp_index(64'(upd_pc), IDX_W));
  assign u_tag = TAG_W'(bp_tag(64'(upd_pc), IDX_W, TAG_W));

  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // bp_clear wins over a simultaneous update; the table write is dropped.
  assign wr_en = upd_valid && !bp_clear;

  assign pred_taken  = l_hit && ctr_q[l_idx][CTR_W-1];
  assign pred_target = pred_taken ? target_q[l_idx] : lookup_pc + XLEN'(4);

  // A taken update always leaves the entry valid with this tag and target:
  // on a hit the tag is unchanged, on a miss the entry is (re)allocated.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (bp_clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (wr_en && upd_taken) begin
      valid_q[u_idx]  <= 1'b1;
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= upd_target;
    end
  end

  // Hits step the counter; a taken miss reloads it as weakly taken.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    logic sel;
    assign sel = wr_en && (u_idx == IDX_W'(i));

    otter_sat_ctr #(.W(CTR_W)) u_ctr (
      .CLK      (CLK),
      .RESET    (RESET),
      .inc      (sel && u_hit && upd_taken),
      .dec      (sel && u_hit && !upd_taken),
      .load     (sel && !u_hit && upd_taken),
      .load_val (CTR_W'(weak_taken_init(CTR_W))),
      .count    (ctr_q[i])
    );
  end

  // Perf counters see every report, even while the table is being cleared.
  otter_sat_ctr #(.W(32)) u_branch_cnt (
    .CLK      (CLK),
    .RESET    (RESET),
    .inc      (upd_valid),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val (32'd0),
    .count    (branch_cnt)
  );

  otter_sat_ctr #(.W(32)) u_mispredict_cnt (
    .CLK      (CLK),
    .RESET    (RESET),
    .inc      (upd_valid && upd_mispredict),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val (32'd0),
    .count    (mispredict_cnt)
  );

endmodule

// File: tb/tb_otter_branch_predictor.sv
// tb_otter_branch_predictor
// Self-checking bench: a behavioural model of the predictor table and perf
// counters is compared against the DUT every falling edge, with directed
// scenarios pinned to hand-computed literals followed by random traffic.
module tb_otter_branch_predictor;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] lookup_pc = 32'h100;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'h0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = 32'h0;
  logic        upd_mispredict = 1'b0;
  logic        bp_clear = 1'b0;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  int passCount = 0;
  int checkCount = 0;

  bit       mValid  [64];
  int       mTag    [64];
  int       mCtr    [64];
  bit [31:0] mTarget [64];
  longint   mBranch = 0;
  longint   mMisp = 0;

  otter_branch_predictor #(.XLEN(32), .ENTRIES(64), .TAG_W(8), .CTR_W(2)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .lookup_pc      (lookup_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict),
    .bp_clear       (bp_clear),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 CLK = ~CLK;

  function automatic int idxOf(input bit [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic int tagOf(input bit [31:0] pc);
    return int'((pc / 256) % 256);
  endfunction

  function automatic bit modelHit(input bit [31:0] pc);
    return mValid[idxOf(pc)] && (mTag[idxOf(pc)] == tagOf(pc));
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  // Reference model: direction counter as an integer clamped to [0,3].
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 64; i++) begin
        mValid[i] = 0; mTag[i] = 0; mCtr[i] = 0; mTarget[i] = 0;
      end
      mBranch = 0;
      mMisp = 0;
    end else begin
      if (upd_valid) begin
        if (mBranch < 64'hFFFF_FFFF) mBranch++;
        if (upd_mispredict && mMisp < 64'hFFFF_FFFF) mMisp++;
        if (!bp_clear) begin
          int i;
          i = idxOf(upd_pc);
          if (modelHit(upd_pc)) begin
            if (upd_taken) begin
              mCtr[i] = (mCtr[i] < 3) ? mCtr[i] + 1 : 3;
              mTarget[i] = upd_target;
            end else begin
              mCtr[i] = (mCtr[i] > 0) ? mCtr[i] - 1 : 0;
            end
          end else if (upd_taken) begin
            mValid[i] = 1; mTag[i] = tagOf(upd_pc);
            mTarget[i] = upd_target; mCtr[i] = 2;
          end
        end
      end
      if (bp_clear) begin
        for (int i = 0; i < 64; i++) mValid[i] = 0;
      end
    end
  end

  // Continuous comparison against the model on every falling edge.
  always @(negedge CLK) begin
    bit        expTaken;
    bit [31:0] expTarget;
    expTaken  = modelHit(lookup_pc) && (mCtr[idxOf(lookup_pc)] >= 2);
    expTarget = expTaken ? mTarget[idxOf(lookup_pc)] : lookup_pc + 32'd4;
    checkOutput("pred_taken", 64'(pred_taken), 64'(expTaken));
    checkOutput("pred_target", 64'(pred_target), 64'(expTarget));
    checkOutput("branch_cnt", 64'(branch_cnt), 64'(mBranch));
    checkOutput("mispredict_cnt", 64'(mispredict_cnt), 64'(mMisp));
  end

  // Presents one update for one rising edge, then withdraws it.
  task automatic applyStimulus(input bit [31:0] pc, input bit taken,
                               input bit [31:0] target, input bit misp,
                               input bit clr);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken;
    upd_target = target; upd_mispredict = misp; bp_clear = clr;
    @(posedge CLK); #1;
    upd_valid = 1'b0; bp_clear = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic probe(input bit [31:0] pc);
    lookup_pc = pc;
    #1;
  endtask

  function automatic bit [31:0] randPc();
    bit [31:0] pc;
    pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
       | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) pc = pc | ($urandom & 32'hFFFF_0000);
    return pc;
  endfunction

  initial begin
    #1 RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;

    probe(32'h100);
    checkOutput("reset_taken", 64'(pred_taken), 64'd0);
    checkOutput("reset_target", 64'(pred_target), 64'h104);
    checkOutput("reset_branch_cnt", 64'(branch_cnt), 64'd0);
    checkOutput("reset_misp_cnt", 64'(mispredict_cnt), 64'd0);

    applyStimulus(32'h100, 1, 32'h80, 0, 0);
    probe(32'h100);
    checkOutput("alloc_taken", 64'(pred_taken), 64'd1);
    checkOutput("alloc_target", 64'(pred_target), 64'h80);
    checkOutput("alloc_model_ctr", 64'(mCtr[0]), 64'd2);
    checkOutput("alloc_branch_cnt", 64'(branch_cnt), 64'd1);

    repeat (2) applyStimulus(32'h100, 0, 32'h0, 0, 0);
    probe(32'h100);
    checkOutput("nt_taken", 64'(pred_taken), 64'd0);
    checkOutput("nt_target", 64'(pred_target), 64'h104);
    checkOutput("nt_model_ctr", 64'(mCtr[0]), 64'd0);
    checkOutput("nt_model_valid", 64'(mValid[0]), 64'd1);

    repeat (5) applyStimulus(32'h100, 1, 32'h80, 0, 0);
    checkOutput("sat_model_ctr", 64'(mCtr[0]), 64'd3);
    applyStimulus(32'h100, 0, 32'h0, 0, 0);
    probe(32'h100);
    checkOutput("sat_dec_model_ctr", 64'(mCtr[0]), 64'd2);
    checkOutput("sat_dec_target", 64'(pred_target), 64'h80);

    probe(32'h200);
    checkOutput("alias_miss_taken", 64'(pred_taken), 64'd0);
    checkOutput("alias_miss_target", 64'(pred_target), 64'h204);
    applyStimulus(32'h200, 1, 32'h40, 0, 0);
    probe(32'h200);
    checkOutput("alias_new_target", 64'(pred_target), 64'h40);
    probe(32'h100);
    checkOutput("alias_old_miss", 64'(pred_target), 64'h104);

    applyStimulus(32'h300, 1, 32'h500, 1, 1);
    probe(32'h300);
    checkOutput("clear_no_alloc", 64'(pred_taken), 64'd0);
    probe(32'h200);
    checkOutput("clear_invalidated", 64'(pred_taken), 64'd0);
    checkOutput("clear_branch_cnt", 64'(branch_cnt), 64'd11);
    checkOutput("clear_misp_cnt", 64'(mispredict_cnt), 64'd1);

    @(posedge CLK); #3;
    RESET = 1'b1;
    #1;
    checkOutput("async_branch_cnt", 64'(branch_cnt), 64'd0);
    checkOutput("async_misp_cnt", 64'(mispredict_cnt), 64'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      upd_valid      = ($urandom_range(0, 3) != 0);
      upd_pc         = randPc();
      upd_taken      = $urandom_range(0, 1) == 1;
      upd_target     = $urandom & 32'hFFFF_FFFC;
      upd_mispredict = $urandom_range(0, 1) == 1;
      bp_clear       = ($urandom_range(0, 40) == 0);
      lookup_pc      = ($urandom_range(0, 50) == 0) ? 32'hFFFF_FFFE : randPc();
      @(posedge CLK); #1;
      if ($urandom_range(0, 400) == 0) begin
        #1 RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
      end
    end
    upd_valid = 1'b0;
    bp_clear = 1'b0;
    @(posedge CLK); #1;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/otter_branch_predictor.md
# otter_branch_predictor

Parametrised branch predictor for the pipelined OTTER CPU. It combines a direct-mapped branch history table of saturating counters with a tagged branch target buffer. The fetch stage looks up the current PC combinationally and receives a predicted direction and next PC. The execute stage reports resolved branch/JAL/JALR outcomes, which train the tables the following cycle. Two saturating performance counters track resolved branches and mispredictions.

## Interface
- XLEN, 32: address/data width.
- ENTRIES, 64: table entries; power of two, ≥2; IDX_W = log2(ENTRIES).
- TAG_W, 8: tag width; requires XLEN ≥ IDX_W+TAG_W+2.
- CTR_W, 2: direction counter width, ≥1.

- CLK  in  1  clock.
- RESET  in  1  reset, asynchronous, active-high.
- lookup_pc  in  XLEN  fetch-stage PC.
- pred_taken  out  1  predicted redirect.
- pred_target  out  XLEN  predicted next PC.
- upd_valid  in  1  EX reports a resolved control-flow instruction this cycle.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_taken  in  1  actual outcome (1 for JAL/JALR).
- upd_target  in  XLEN  actual target.
- upd_mispredict  in  1  EX-detected misprediction; only qualified by upd_valid.
- bp_clear  in  1  synchronous invalidate of all entries (fence.i, context switch).
- branch_cnt  out  32  resolved updates, saturating.
- mispredict_cnt  out  32  mispredictions, saturating.

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]; pc[1:0] ignored.
- Entry fields: valid, tag, ctr (CTR_W), target (XLEN).
- Lookup: hit = valid && tag match. pred_taken = hit && ctr[CTR_W-1]. pred_target = pred_taken ? target : lookup_pc+4, with modulo-2^XLEN wrap.
- Update on posedge CLK when upd_valid && !bp_clear:
  - Hit: ctr increments if taken, decrements if not, saturating at 0 and 2^CTR_W−1. The target is overwritten only when taken.
  - Miss and taken: allocate or replace the entry. Set valid=1, write tag and target, and set ctr = 2^(CTR_W−1) (weakly taken).
  - Miss and not taken: no table change.
- bp_clear: clears every valid bit the next edge. It has priority over a simultaneous update, and the table write is dropped. Perf counters are not cleared by bp_clear.
- Perf counters: branch_cnt increments on every upd_valid. mispredict_cnt increments on upd_valid && upd_mispredict. Both hold at 32'hFFFF_FFFF. This applies even while bp_clear is asserted.

## Timing
- Lookup latency 0 cycles (combinational from lookup_pc and table flops).
- Update latency 1 cycle: the result is visible to a lookup on the cycle after the edge.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents. There is no bypass.
- Reset (asynchronous, any cycle, including mid-update):
  - All valid=0, ctr=0, target=0, tag=0.
  - branch_cnt=0, mispredict_cnt=0.
  - Outputs then read pred_taken=0 and pred_target=lookup_pc+4.
- The table is held in flops, not BRAM, so combinational read is legal.

## Structure
- Package otter_bp_pkg: the weak-taken init constant function and the index/tag extraction functions, parameterised by IDX_W/TAG_W. opcode_t and branch_t stay in the CPU's shared package.
- Sub-module otter_sat_ctr: a CTR_W-wide saturating up/down counter with load. It is instantiated per entry, and the same module implements the 32-bit perf counters.

## Test plan
- Reset, then lookup_pc=0x100 -> pred_taken=0, pred_target=0x104; both perf counters are 0.
- Update pc=0x100, taken, target=0x80 -> next cycle lookup 0x100 gives pred_taken=1, pred_target=0x80, ctr=2; branch_cnt=1.
- From that state, two not-taken updates to 0x100 -> ctr=0; lookup gives pred_taken=0, pred_target=0x104. The entry is still valid.
- Saturation: 5 taken updates to 0x100 -> ctr=3. One not-taken update -> ctr=2, still predicts 0x80.
- Aliasing (ENTRIES=64): train 0x100 taken. Lookup 0x200 (same index, different tag) -> miss, pred_target=0x204. A taken update to 0x200→0x40 replaces the entry, and 0x100 then misses.
- bp_clear asserted together with a taken upd_valid (upd_mispredict=1) to 0x300:
  - Next cycle all lookups miss and 0x300 is not allocated.
  - branch_cnt and mispredict_cnt each increment by 1.
  - Async RESET mid-sequence zeroes both counters immediately.
